regfile_read: RTL
=================

// Module: regfile_read
// PURPOSE
//  Decode-side read port unit for the 8-entry register file: resolves source IDs rA/rB into
//  operands valA/valB for the execute stage. Reads the flat register bus, bypasses same-cycle
//  writebacks (dstE/valE, dstM/valM), tracks pending memory loads in a scoreboard, and stalls
//  decode until operands are valid. A registered valid/ready stage feeds execute.
// PARAMETERS
//  NREG  8   number of architectural registers (IDs 0..NREG-1)
//  DW    32  data width
//  RW    4   register ID width; ID 4'hF = RNONE
// PORTS
//  clock      in   1        single clock, rising edge
//  reset      in   1        synchronous, active-high
//  regs       in   NREG*DW  register file contents, r0 at [DW-1:0]
//  dstE       in   RW       writeback ALU destination this cycle (RNONE = none)
//  valE       in   DW       writeback ALU data
//  dstM       in   RW       writeback load destination this cycle (RNONE = none)
//  valM       in   DW       writeback load data
//  in_valid   in   1        decode presents rA/rB/in_dstM
//  in_ready   out  1        unit accepts request this cycle
//  rA         in   RW       source A ID
//  rB         in   RW       source B ID
//  in_dstM    in   RW       load destination of this instruction (RNONE if not a load)
//  out_valid  out  1        valA/valB valid toward execute
//  out_ready  in   1        execute consumes
//  valA       out  DW       operand A
//  valB       out  DW       operand B
//  busy       out  NREG     scoreboard bits (debug/hazard visibility)
// BEHAVIOUR
//  - Reset: out_valid=0, valA=0, valB=0, busy=0; in_ready=0 during reset cycle.
//  - ID >= NREG (incl. RNONE): operand = 0, never busy, never stalls.
//  - Operand select: valM if ID==dstM, else valE if ID==dstE, else regs[ID] (M beats E, as
//    the regfile commits M last on dstE==dstM).
//  - hazard(x) = busy[x] && !(x==dstM) ; stall = in_valid && (hazard(rA) || hazard(rB)).
//  - in_ready = !reset && !stall && (!out_valid || out_ready) (combinational).
//  - Accept (in_valid && in_ready): next edge loads valA/valB, out_valid=1. Latency 1 cycle.
//  - out_valid && !out_ready: valA/valB/out_valid hold; no new accept.
//  - out_ready && !accept: out_valid clears next edge.
//  - Scoreboard: on accept with in_dstM<NREG set busy[in_dstM]; dstM<NREG clears busy[dstM].
//    Same-reg set and clear in one cycle: set wins (new pending load). dstE never clears busy.
//  - rA==rB legal; both ports resolve identically.
//  - Reset mid-operation: pending output dropped, scoreboard cleared; writebacks that cycle ignored.
// CONFIGURATION
//  REGREAD_FWD_EN defined: bypass as above.
//  REGREAD_FWD_EN undefined: operand = regs[ID] only; any source equal to a valid dstE or dstM
//    this cycle also stalls (one-cycle bubble until regfile commits); hazard(x)=busy[x].
// STRUCTURE
//  regfile_pkg: RNONE=4'hF, NREG, DW, RW constants, reg_id_t typedef.
//  Sub-module reg_scoreboard: busy vector set/clear logic and hazard lookup per port.
//  Top holds operand muxes, stall logic, output register.
// TESTING
//  1 reset 2 cycles, regs r3=32'h11 -> out_valid=0,valA=valB=0,busy=0; rA=3,rB=RNONE -> 1 cycle later valA=32'h11,valB=0.
//  2 FWD_EN: rA=2,dstE=2,valE=32'hABCDEF98,dstM=2,valM=32'h7654321A same cycle -> valA=32'h7654321A.
//  3 load in_dstM=5 accepted; next req rA=5 -> in_ready=0 until dstM=5,valM=32'hCAFE -> accept, valA=32'hCAFE (FWD_EN) / one extra stall cycle (no FWD_EN).
//  4 out_ready=0 for 3 cycles with in_valid=1 -> valA/valB stable, in_ready=0; out_ready=1 -> next request loads following edge.
//  5 accept in_dstM=4 same cycle dstM=4 -> busy[4]=1 after edge.
//  6 reset asserted while busy=8'h30 and out_valid=1 -> next edge busy=0,out_valid=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and ID type for the register-file read path.
package regfile_pkg;
   localparam int NREG = 8;
   localparam int DW   = 32;
   localparam int RW   = 4;
   localparam logic [RW-1:0] RNONE = 4'hF;
   typedef logic [RW-1:0] reg_id_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: busy bit per register plus per-port hazard lookup.
// REGREAD_FWD_EN: a load completing this cycle masks its own hazard (bypass supplies it).
module reg_scoreboard #(
   parameter int NREG  = regfile_pkg::NREG,
   parameter int RW    = regfile_pkg::RW,
   parameter int NPORT = 2
)(
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       setEn,
   input  logic [RW-1:0]              setId,
   input  logic [RW-1:0]              clrId,
   input  logic [NPORT-1:0][RW-1:0]   rdId,
   output logic [NREG-1:0]            busy,
   output logic [NPORT-1:0]           hazard
);
   // A new pending load beats the completion of an older one to the same register.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (setEn && setId == RW'(i))
               busy[i] <= 1'b1;
            else if (clrId == RW'(i))
               busy[i] <= 1'b0;
         end
      end
   end

   for (genvar p = 0; p < NPORT; p++) begin : gPort
      logic [NREG-1:0] hit;
      always_comb begin
         hit = '0;
         for (int i = 0; i < NREG; i++)
            hit[i] = busy[i] && (rdId[p] == RW'(i));
      end
`ifdef REGREAD_FWD_EN
      assign hazard[p] = (|hit) && (rdId[p] != clrId);
`else
      assign hazard[p] = |hit;
`endif
   end
endmodule

// File: rtl/regfile_read.sv
// Decode read-port unit: operand select, load-hazard stall, one-entry output register.
// REGREAD_FWD_EN enables same-cycle writeback bypass; otherwise matching writebacks stall.
module regfile_read #(
   parameter int NREG = regfile_pkg::NREG,
   parameter int DW   = regfile_pkg::DW,
   parameter int RW   = regfile_pkg::RW
)(
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREG*DW-1:0]   regs,
   input  logic [RW-1:0]        dstE,
   input  logic [DW-1:0]        valE,
   input  logic [RW-1:0]        dstM,
   input  logic [DW-1:0]        valM,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [RW-1:0]        rA,
   input  logic [RW-1:0]        rB,
   input  logic [RW-1:0]        in_dstM,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        valA,
   output logic [DW-1:0]        valB,
   output logic [NREG-1:0]      busy
);
   import regfile_pkg::*;

   function automatic logic inRange(logic [RW-1:0] id);
      return {{(32-RW){1'b0}}, id} < 32'(NREG);
   endfunction

   reg_id_t [1:0]         srcId;
   logic [1:0][DW-1:0]    opnd;
   logic [1:0]            hazard;
   logic [1:0]            wbHit;
   logic                  stall, accept, outValid;

   assign srcId = {rB, rA};

   for (genvar p = 0; p < 2; p++) begin : gPort
      logic [DW-1:0] sel;
      always_comb begin
         sel = '0;
         for (int i = 0; i < NREG; i++)
            if (srcId[p] == RW'(i)) sel = regs[i*DW +: DW];
`ifdef REGREAD_FWD_EN
         // M is applied after E: the regfile commits the load last on a shared destination.
         if (inRange(srcId[p])) begin
            if (srcId[p] == dstE) sel = valE;
            if (srcId[p] == dstM) sel = valM;
         end
`endif
      end
      assign opnd[p] = sel;
`ifdef REGREAD_FWD_EN
      assign wbHit[p] = 1'b0;
`else
      assign wbHit[p] = inRange(srcId[p]) && (srcId[p] == dstE || srcId[p] == dstM);
`endif
   end

   reg_scoreboard #(.NREG(NREG), .RW(RW), .NPORT(2)) uSb (
      .clock  (clock),
      .reset  (reset),
      .setEn  (accept),
      .setId  (in_dstM),
      .clrId  (dstM),
      .rdId   (srcId),
      .busy   (busy),
      .hazard (hazard)
   );

   assign stall    = in_valid && ((|hazard) || (|wbHit));
   assign in_ready = !reset && !stall && (!outValid || out_ready);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         outValid <= 1'b0;
         valA     <= '0;
         valB     <= '0;
      end else if (accept) begin
         outValid <= 1'b1;
         valA     <= opnd[0];
         valB     <= opnd[1];
      end else if (out_ready) begin
         outValid <= 1'b0;
      end
   end

   assign out_valid = outValid;
endmodule
